// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: receiver handshake on one side, controller read port on the other.
// Signal directions are named from the FIFO's point of view.
interface uart_rx_fifo_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned DEPTH     = 16
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WORD_SIZE-1:0] i_rx_data;
  logic                 i_rx_irq;
  logic                 o_rx_ack;
  logic                 i_rd_en;
  logic [WORD_SIZE-1:0] o_rd_data;
  logic                 o_empty;
  logic                 o_full;
  logic [CntW-1:0]      o_count;
  logic                 o_overflow;
  logic                 i_clr_overflow;

  // Environment side: receiver plus controller.
  modport master (
    output i_rx_data, i_rx_irq, i_rd_en, i_clr_overflow,
    input  o_rx_ack, o_rd_data, o_empty, o_full, o_count, o_overflow
  );

  // FIFO side.
  modport slave (
    input  i_rx_data, i_rx_irq, i_rd_en, i_clr_overflow,
    output o_rx_ack, o_rd_data, o_empty, o_full, o_count, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: captures one word per rx_irq level,
// acknowledges it, and queues it in a show-ahead FIFO. Words that find the FIFO full
// are dropped and flagged in a sticky overflow bit.
module uart_rx_fifo #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned DEPTH     = 16
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_rx_ack;
  logic [AddrW-1:0]     r_wr_ptr;
  logic [AddrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 r_overflow;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic w_capture;
  logic w_pop;
  logic w_write;
  logic w_drop;

  // Capture FSM next state: one capture per rx_irq level, then wait for the level to drop.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_rx_irq) begin
          w_capture    = 1'b1;
          w_state_next = StAck;
        end
      end
      StAck: begin
        if (!bus.i_rx_irq) begin
          w_state_next = StIdle;
        end
      end
    endcase
  end

  // A full FIFO still accepts a word when the same-cycle pop frees the head slot.
  always_comb begin
    w_pop   = bus.i_rd_en && (r_count != '0);
    w_write = w_capture && ((r_count != FullCnt) || w_pop);
    w_drop  = w_capture && !w_write;
  end

  // FSM state and registered acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rx_ack <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rx_ack <= (w_state_next == StAck);
    end
  end

  // Pointers and occupancy; count moves only when exactly one of write/pop happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AddrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AddrW'(1);
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_write) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (!rst && w_write) begin
      r_mem[r_wr_ptr] <= bus.i_rx_data;
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.o_rx_ack   = r_rx_ack;
  assign bus.o_rd_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.o_empty    = (r_count == '0);
  assign bus.o_full     = (r_count == FullCnt);
  assign bus.o_count    = r_count;
  assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by random traffic, checked every
// cycle against a queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;
  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned DEPTH     = 16;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: stored words, sticky flag, and "handshake in progress".
  logic [WORD_SIZE-1:0] m_q[$];
  bit                   m_ovf;
  bit                   m_busy;
  bit                   m_known;
  int                   n_vec;
  int                   n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor and model: compare registered outputs mid-cycle, then advance the model
  // with the inputs the DUT will sample at the coming rising edge.
  always @(negedge clk) begin
    bit                   pop;
    bit                   cap;
    bit                   acc;
    logic [WORD_SIZE-1:0] head;
    pop = 1'b0;
    if (m_known) begin
      chk("count", int'(bus.o_count), m_q.size());
      chk("empty", int'(bus.o_empty), int'(m_q.size() == 0));
      chk("full", int'(bus.o_full), int'(m_q.size() == int'(DEPTH)));
      chk("overflow", int'(bus.o_overflow), int'(m_ovf));
      chk("rx_ack", int'(bus.o_rx_ack), int'(m_busy));
      pop = !rst && bus.i_rd_en && (m_q.size() > 0);
      if (pop) begin
        head = m_q.pop_front();
        chk("pop_data", int'(bus.o_rd_data), int'(head));
      end else begin
        head = (m_q.size() > 0) ? m_q[0] : '0;
        chk("rd_data", int'(bus.o_rd_data), int'(head));
      end
    end
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_busy  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      cap = bus.i_rx_irq && !m_busy;
      // Queue already reflects the pop, so a full buffer with a pop has room.
      acc = cap && (m_q.size() < int'(DEPTH));
      if (acc) m_q.push_back(bus.i_rx_data);
      if (cap && !acc)             m_ovf = 1'b1;
      else if (bus.i_clr_overflow) m_ovf = 1'b0;
      if (cap)                 m_busy = 1'b1;
      else if (!bus.i_rx_irq)  m_busy = 1'b0;
    end
  end

  // Receiver behaviour: raise rx_irq with a word, drop it one edge after seeing rx_ack.
  // Optional rd_en / clr_overflow are applied only in the capture cycle.
  task automatic send(input logic [WORD_SIZE-1:0] data, input bit pop, input bit clr);
    int waited;
    bus.i_rx_data      = data;
    bus.i_rx_irq       = 1'b1;
    bus.i_rd_en        = pop;
    bus.i_clr_overflow = clr;
    @(posedge clk); #1;
    bus.i_rd_en        = 1'b0;
    bus.i_clr_overflow = 1'b0;
    waited = 0;
    while (!bus.o_rx_ack) begin
      if (waited == 8) begin
        $display("FAIL ack_timeout at %0t: rx_ack stayed 0, expected 1", $time);
        $fatal(1, "rx_ack never asserted");
      end
      waited++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.i_rx_irq  = 1'b0;
    bus.i_rx_data = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_rd_en = 1'b1;
      @(posedge clk); #1;
    end
    bus.i_rd_en = 1'b0;
  endtask

  task automatic clr_ovf();
    bus.i_clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.i_clr_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: simulation still running, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_known = 1'b0;
    m_ovf   = 1'b0;
    m_busy  = 1'b0;
    rst                = 1'b1;
    bus.i_rx_data      = '0;
    bus.i_rx_irq       = 1'b0;
    bus.i_rd_en        = 1'b0;
    bus.i_clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single word round trip.
    send(8'hA5, 1'b0, 1'b0);
    pop_n(1);
    idle(2);

    // Fill, overflow on the 17th word, drain in order.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    pop_n(16);
    clr_ovf();

    // Capture while full with a same-cycle pop.
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    pop_n(16);
    idle(1);

    // Wrap-around with low occupancy.
    for (int i = 0; i < 40; i++) begin
      send(8'(8'h80 + i), 1'b0, 1'b0);
      pop_n(1);
    end

    // Drop coincident with clear: set wins, then a lone clear takes effect.
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b1);
    clr_ovf();
    pop_n(16);

    // Reset while in the acknowledge phase with words held.
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
    bus.i_rx_data = 8'h77;
    bus.i_rx_irq  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_rx_irq = 1'b0;
    @(posedge clk); #1;
    pop_n(1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        3:       pop_n(int'($urandom_range(1, 3)));
        4:       clr_ovf();
        default: idle(1);
      endcase
    end
    pop_n(DEPTH);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
